// File: rtl/roce_qp_context_table.sv
// Per-QP connection context for the RoCEv2 transmit path: flop-based table with
// 1-cycle registered lookups, state-checked config writes and RTS-only PSN advance.
module roce_qp_context_table #(
    parameter int MAX_QUEUE_PAIRS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_cfg_valid,
    input  logic [23:0] s_cfg_loc_qpn,
    input  logic [2:0]  s_cfg_state,
    input  logic [31:0] s_cfg_r_key,
    input  logic [23:0] s_cfg_rem_qpn,
    input  logic [23:0] s_cfg_rem_psn,
    input  logic [23:0] s_cfg_loc_psn,
    input  logic [31:0] s_cfg_rem_ip_addr,
    input  logic [63:0] s_cfg_rem_addr,
    output logic        m_cfg_err,
    input  logic        s_qp_context_req,
    input  logic [23:0] s_qp_local_qpn_req,
    output logic        m_qp_context_valid,
    output logic [2:0]  m_qp_state,
    output logic [31:0] m_qp_r_key,
    output logic [23:0] m_qp_rem_qpn,
    output logic [23:0] m_qp_loc_qpn,
    output logic [23:0] m_qp_rem_psn,
    output logic [23:0] m_qp_loc_psn,
    output logic [31:0] m_qp_rem_ip_addr,
    output logic [63:0] m_qp_rem_addr,
    output logic        m_qp_lookup_err,
    input  logic        s_psn_upd_valid,
    input  logic [23:0] s_psn_upd_loc_qpn,
    input  logic [23:0] s_psn_upd_npkts
);
    localparam int IDX_W = $clog2(MAX_QUEUE_PAIRS);

    localparam logic [2:0] ST_RESET    = 3'd0;
    localparam logic [2:0] ST_INIT     = 3'd1;
    localparam logic [2:0] ST_RTR      = 3'd2;
    localparam logic [2:0] ST_RTS      = 3'd3;
    localparam logic [2:0] ST_SQ_DRAIN = 3'd4;
    localparam logic [2:0] ST_ERROR    = 3'd6;

    function automatic logic f_in_range(input logic [23:0] qpn);
        return (qpn[23:8] == 16'h0001) && ((qpn[7:0] >> IDX_W) == 8'd0);
    endfunction

    function automatic logic f_legal(input logic [2:0] cur, input logic [2:0] nxt);
        logic ok;
        ok = 1'b0;
        if (nxt == 3'd7)                               ok = 1'b0;
        else if (nxt == cur)                           ok = 1'b1;
        else if (nxt == ST_ERROR || nxt == ST_RESET)   ok = 1'b1;
        else if (cur == ST_RESET    && nxt == ST_INIT)     ok = 1'b1;
        else if (cur == ST_INIT     && nxt == ST_RTR)      ok = 1'b1;
        else if (cur == ST_RTR      && nxt == ST_RTS)      ok = 1'b1;
        else if (cur == ST_RTS      && nxt == ST_SQ_DRAIN) ok = 1'b1;
        else if (cur == ST_SQ_DRAIN && nxt == ST_RTS)      ok = 1'b1;
        return ok;
    endfunction

    logic [2:0]  r_state     [MAX_QUEUE_PAIRS];
    logic [31:0] r_r_key     [MAX_QUEUE_PAIRS];
    logic [23:0] r_rem_qpn   [MAX_QUEUE_PAIRS];
    logic [23:0] r_rem_psn   [MAX_QUEUE_PAIRS];
    logic [23:0] r_loc_psn   [MAX_QUEUE_PAIRS];
    logic [31:0] r_rem_ip    [MAX_QUEUE_PAIRS];
    logic [63:0] r_rem_addr  [MAX_QUEUE_PAIRS];

    logic [IDX_W-1:0] w_cfg_idx, w_psn_idx, w_lk_idx;
    logic             w_cfg_ok, w_psn_ok, w_lk_hit;

    assign w_cfg_idx = s_cfg_loc_qpn[IDX_W-1:0];
    assign w_psn_idx = s_psn_upd_loc_qpn[IDX_W-1:0];
    assign w_lk_idx  = s_qp_local_qpn_req[IDX_W-1:0];
    assign w_cfg_ok  = s_cfg_valid && f_in_range(s_cfg_loc_qpn)
                       && f_legal(r_state[w_cfg_idx], s_cfg_state);
    assign w_psn_ok  = s_psn_upd_valid && f_in_range(s_psn_upd_loc_qpn)
                       && (r_state[w_psn_idx] == ST_RTS);
    assign w_lk_hit  = f_in_range(s_qp_local_qpn_req);

    // A legal config write to an entry shadows a same-cycle PSN advance to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_QUEUE_PAIRS; i++) begin
                r_state[i]    <= ST_RESET;
                r_r_key[i]    <= '0;
                r_rem_qpn[i]  <= '0;
                r_rem_psn[i]  <= '0;
                r_loc_psn[i]  <= '0;
                r_rem_ip[i]   <= '0;
                r_rem_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_QUEUE_PAIRS; i++) begin
                if (w_cfg_ok && w_cfg_idx == IDX_W'(i)) begin
                    if (s_cfg_state == ST_RESET) begin
                        r_state[i]    <= ST_RESET;
                        r_r_key[i]    <= '0;
                        r_rem_qpn[i]  <= '0;
                        r_rem_psn[i]  <= '0;
                        r_loc_psn[i]  <= '0;
                        r_rem_ip[i]   <= '0;
                        r_rem_addr[i] <= '0;
                    end else begin
                        r_state[i]    <= s_cfg_state;
                        r_r_key[i]    <= s_cfg_r_key;
                        r_rem_qpn[i]  <= s_cfg_rem_qpn;
                        r_rem_psn[i]  <= s_cfg_rem_psn;
                        r_loc_psn[i]  <= s_cfg_loc_psn;
                        r_rem_ip[i]   <= s_cfg_rem_ip_addr;
                        r_rem_addr[i] <= s_cfg_rem_addr;
                    end
                end else if (w_psn_ok && w_psn_idx == IDX_W'(i)) begin
                    r_rem_psn[i] <= r_rem_psn[i] + s_psn_upd_npkts;
                end
            end
        end
    end

    logic        r_rsp_valid, r_rsp_err, r_cfg_err;
    logic [2:0]  r_rsp_state;
    logic [31:0] r_rsp_r_key, r_rsp_rem_ip;
    logic [23:0] r_rsp_rem_qpn, r_rsp_loc_qpn, r_rsp_rem_psn, r_rsp_loc_psn;
    logic [63:0] r_rsp_rem_addr;

    // Response fields only change on a request so they hold while valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_cfg_err      <= 1'b0;
            r_rsp_state    <= ST_RESET;
            r_rsp_r_key    <= '0;
            r_rsp_rem_qpn  <= '0;
            r_rsp_loc_qpn  <= '0;
            r_rsp_rem_psn  <= '0;
            r_rsp_loc_psn  <= '0;
            r_rsp_rem_ip   <= '0;
            r_rsp_rem_addr <= '0;
        end else begin
            r_rsp_valid <= s_qp_context_req;
            r_rsp_err   <= s_qp_context_req && !w_lk_hit;
            r_cfg_err   <= s_cfg_valid && !w_cfg_ok;
            if (s_qp_context_req) begin
                if (w_lk_hit) begin
                    r_rsp_state    <= r_state[w_lk_idx];
                    r_rsp_r_key    <= r_r_key[w_lk_idx];
                    r_rsp_rem_qpn  <= r_rem_qpn[w_lk_idx];
                    r_rsp_loc_qpn  <= 24'h000100 | 24'(w_lk_idx);
                    r_rsp_rem_psn  <= r_rem_psn[w_lk_idx];
                    r_rsp_loc_psn  <= r_loc_psn[w_lk_idx];
                    r_rsp_rem_ip   <= r_rem_ip[w_lk_idx];
                    r_rsp_rem_addr <= r_rem_addr[w_lk_idx];
                end else begin
                    r_rsp_state    <= ST_RESET;
                    r_rsp_r_key    <= '0;
                    r_rsp_rem_qpn  <= '0;
                    r_rsp_loc_qpn  <= s_qp_local_qpn_req;
                    r_rsp_rem_psn  <= '0;
                    r_rsp_loc_psn  <= '0;
                    r_rsp_rem_ip   <= '0;
                    r_rsp_rem_addr <= '0;
                end
            end
        end
    end

    assign m_qp_context_valid = r_rsp_valid;
    assign m_qp_lookup_err    = r_rsp_err;
    assign m_cfg_err          = r_cfg_err;
    assign m_qp_state         = r_rsp_state;
    assign m_qp_r_key         = r_rsp_r_key;
    assign m_qp_rem_qpn       = r_rsp_rem_qpn;
    assign m_qp_loc_qpn       = r_rsp_loc_qpn;
    assign m_qp_rem_psn       = r_rsp_rem_psn;
    assign m_qp_loc_psn       = r_rsp_loc_psn;
    assign m_qp_rem_ip_addr   = r_rsp_rem_ip;
    assign m_qp_rem_addr      = r_rsp_rem_addr;

endmodule
